// File: rtl/mem_access.sv
// Memory-access stage: issues loads/stores over a req/ack data-memory port,
// extracts and extends load lanes, and emits a registered write-back packet.
module mem_access #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    input  logic [1:0]                mem_op_i,
    input  logic [1:0]                mem_size_i,
    input  logic                      mem_unsigned_i,
    input  logic [DATA_WIDTH-1:0]     result_i,
    input  logic [DATA_WIDTH-1:0]     store_data_i,
    input  logic [REG_ADDR_WIDTH-1:0] dest_reg_addr_i,
    input  logic                      wb_en_i,
    output logic                      stall_o,
    output logic                      dmem_req_o,
    output logic                      dmem_we_o,
    output logic [DATA_WIDTH-1:0]     dmem_addr_o,
    output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
    output logic [3:0]                dmem_be_o,
    input  logic                      dmem_ack_i,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
    output logic                      valid_o,
    output logic                      wb_en_o,
    output logic [REG_ADDR_WIDTH-1:0] dest_reg_addr_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    output logic                      misalign_o
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                    state, state_next;
    logic [DATA_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     store_data_q;
    logic [1:0]                size_q;
    logic                      unsigned_q;
    logic                      store_q;
    logic                      wb_en_q;
    logic [REG_ADDR_WIDTH-1:0] dest_q;

    logic is_mem;
    logic misaligned;
    logic accept;

    function automatic logic [31:0] extract_load(input logic [31:0] rdata,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  offset,
                                                 input logic        zero_ext);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[7:0];
        case (offset)
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            2'd3:    b = rdata[31:24];
            default: b = rdata[7:0];
        endcase
        h = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   extract_load = zero_ext ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   extract_load = zero_ext ? {16'h0, h} : {{16{h[15]}}, h};
            default: extract_load = rdata;
        endcase
    endfunction

    // Size 11 is a word; op 11 is reserved and behaves as a non-memory op.
    assign is_mem     = (mem_op_i == 2'b01) || (mem_op_i == 2'b10);
    assign misaligned = ((mem_size_i == 2'b01) && result_i[0]) ||
                        (mem_size_i[1] && (result_i[1:0] != 2'b00));
    assign accept     = (state == IDLE) && valid_i && is_mem && !misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = WAIT;
            WAIT:    if (dmem_ack_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign stall_o      = (state == WAIT);
    assign dmem_req_o   = (state == WAIT);
    assign dmem_we_o    = (state == WAIT) && store_q;
    assign dmem_addr_o  = {addr_q[DATA_WIDTH-1:2], 2'b00};

    always_comb begin
        dmem_be_o    = 4'b1111;
        dmem_wdata_o = store_data_q;
        case (size_q)
            2'b00: begin
                dmem_be_o    = 4'b0001 << addr_q[1:0];
                dmem_wdata_o = {4{store_data_q[7:0]}};
            end
            2'b01: begin
                dmem_be_o    = 4'b0011 << addr_q[1:0];
                dmem_wdata_o = {2{store_data_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            store_data_q <= '0;
            size_q       <= '0;
            unsigned_q   <= 1'b0;
            store_q      <= 1'b0;
            wb_en_q      <= 1'b0;
            dest_q       <= '0;
        end else if (accept) begin
            addr_q       <= result_i;
            store_data_q <= store_data_i;
            size_q       <= mem_size_i;
            unsigned_q   <= mem_unsigned_i;
            store_q      <= (mem_op_i == 2'b10);
            wb_en_q      <= wb_en_i;
            dest_q       <= dest_reg_addr_i;
        end
    end

    // Write-back packet register; valid and misalign are single-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o         <= 1'b0;
            wb_en_o         <= 1'b0;
            dest_reg_addr_o <= '0;
            wb_data_o       <= '0;
            misalign_o      <= 1'b0;
        end else begin
            valid_o    <= 1'b0;
            misalign_o <= 1'b0;
            if (state == IDLE && valid_i) begin
                if (!is_mem) begin
                    valid_o         <= 1'b1;
                    wb_en_o         <= wb_en_i;
                    dest_reg_addr_o <= dest_reg_addr_i;
                    wb_data_o       <= result_i;
                end else if (misaligned) begin
                    valid_o         <= 1'b1;
                    wb_en_o         <= 1'b0;
                    dest_reg_addr_o <= dest_reg_addr_i;
                    wb_data_o       <= '0;
                    misalign_o      <= 1'b1;
                end
            end else if (state == WAIT && dmem_ack_i) begin
                valid_o         <= 1'b1;
                dest_reg_addr_o <= dest_q;
                wb_en_o         <= store_q ? 1'b0 : wb_en_q;
                wb_data_o       <= store_q ? '0
                                           : extract_load(dmem_rdata_i, size_q, addr_q[1:0], unsigned_q);
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; inputs driven and outputs sampled on the falling edge.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [1:0]  mem_op_i;
    logic [1:0]  mem_size_i;
    logic        mem_unsigned_i;
    logic [31:0] result_i;
    logic [31:0] store_data_i;
    logic [4:0]  dest_reg_addr_i;
    logic        wb_en_i;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        valid_o;
    logic        wb_en_o;
    logic [4:0]  dest_reg_addr_o;
    logic [31:0] wb_data_o;
    logic        misalign_o;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op_i(mem_op_i),
        .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
        .result_i(result_i), .store_data_i(store_data_i),
        .dest_reg_addr_i(dest_reg_addr_i), .wb_en_i(wb_en_i),
        .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_be_o(dmem_be_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o), .wb_en_o(wb_en_o),
        .dest_reg_addr_o(dest_reg_addr_o), .wb_data_o(wb_data_o),
        .misalign_o(misalign_o)
    );

    task automatic drive_packet(input logic [1:0] op, input logic [1:0] size, input logic uns,
                                input logic [31:0] res, input logic [31:0] sdata,
                                input logic [4:0] dest, input logic wb_en);
        valid_i = 1'b1; mem_op_i = op; mem_size_i = size; mem_unsigned_i = uns;
        result_i = res; store_data_i = sdata; dest_reg_addr_i = dest; wb_en_i = wb_en;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b0; mem_op_i = 2'b00; mem_size_i = 2'b00; mem_unsigned_i = 1'b0;
        result_i = '0; store_data_i = '0; dest_reg_addr_i = '0; wb_en_i = 1'b0;
        dmem_ack_i = 1'b0; dmem_rdata_i = '0;
        repeat (2) @(negedge clk);
        total++; if (valid_o !== 1'b0) $display("FAIL rst_valid: got %h want 0", valid_o); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL rst_stall: got %h want 0", stall_o); else passed++;
        total++; if (dmem_req_o !== 1'b0) $display("FAIL rst_req: got %h want 0", dmem_req_o); else passed++;
        total++; if (wb_data_o !== 32'h0) $display("FAIL rst_wbdata: got %h want 0", wb_data_o); else passed++;
        total++; if (misalign_o !== 1'b0) $display("FAIL rst_misalign: got %h want 0", misalign_o); else passed++;
        total++; if (dmem_addr_o !== 32'h0) $display("FAIL rst_addr: got %h want 0", dmem_addr_o); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        drive_packet(2'b00, 2'b00, 1'b0, 32'h0000_002A, 32'h0, 5'd5, 1'b1);
        total++; if (stall_o !== 1'b0) $display("FAIL pt_stall0: got %h want 0", stall_o); else passed++;
        @(negedge clk);
        total++; if (valid_o !== 1'b1) $display("FAIL pt_valid: got %h want 1", valid_o); else passed++;
        total++; if (wb_data_o !== 32'h2A) $display("FAIL pt_data: got %h want 0000002a", wb_data_o); else passed++;
        total++; if (dest_reg_addr_o !== 5'd5) $display("FAIL pt_dest: got %0d want 5", dest_reg_addr_o); else passed++;
        total++; if (wb_en_o !== 1'b1) $display("FAIL pt_wben: got %h want 1", wb_en_o); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL pt_stall1: got %h want 0", stall_o); else passed++;
        // reserved op, back to back, wb_en low
        drive_packet(2'b11, 2'b10, 1'b0, 32'h0000_0099, 32'h0, 5'd8, 1'b0);
        @(negedge clk);
        total++; if (valid_o !== 1'b1) $display("FAIL rsv_valid: got %h want 1", valid_o); else passed++;
        total++; if (wb_data_o !== 32'h99) $display("FAIL rsv_data: got %h want 00000099", wb_data_o); else passed++;
        total++; if (wb_en_o !== 1'b0) $display("FAIL rsv_wben: got %h want 0", wb_en_o); else passed++;
        total++; if (dmem_req_o !== 1'b0) $display("FAIL rsv_req: got %h want 0", dmem_req_o); else passed++;
        valid_i = 1'b0;
        @(negedge clk);
        total++; if (valid_o !== 1'b0) $display("FAIL pt_idle_valid: got %h want 0", valid_o); else passed++;
    endtask

    task automatic test_load_byte(input logic uns, input logic [31:0] expected);
        drive_packet(2'b01, 2'b00, uns, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
        @(negedge clk);
        valid_i = 1'b0;
        total++; if (dmem_req_o !== 1'b1) $display("FAIL lb_req: got %h want 1", dmem_req_o); else passed++;
        total++; if (dmem_addr_o !== 32'h100) $display("FAIL lb_addr: got %h want 00000100", dmem_addr_o); else passed++;
        total++; if (dmem_be_o !== 4'b1000) $display("FAIL lb_be: got %b want 1000", dmem_be_o); else passed++;
        total++; if (dmem_we_o !== 1'b0) $display("FAIL lb_we: got %h want 0", dmem_we_o); else passed++;
        for (int c = 0; c < 3; c++) begin
            total++; if (stall_o !== 1'b1) $display("FAIL lb_stall%0d: got %h want 1", c, stall_o); else passed++;
            total++; if (valid_o !== 1'b0) $display("FAIL lb_novalid%0d: got %h want 0", c, valid_o); else passed++;
            if (c == 2) begin dmem_ack_i = 1'b1; dmem_rdata_i = 32'h80FF_1234; end
            @(negedge clk);
        end
        dmem_ack_i = 1'b0;
        total++; if (stall_o !== 1'b0) $display("FAIL lb_stall_end: got %h want 0", stall_o); else passed++;
        total++; if (valid_o !== 1'b1) $display("FAIL lb_valid: got %h want 1", valid_o); else passed++;
        total++; if (wb_data_o !== expected) $display("FAIL lb_data: got %h want %h", wb_data_o, expected); else passed++;
        total++; if (wb_en_o !== 1'b1) $display("FAIL lb_wben: got %h want 1", wb_en_o); else passed++;
        total++; if (dest_reg_addr_o !== 5'd7) $display("FAIL lb_dest: got %0d want 7", dest_reg_addr_o); else passed++;
    endtask

    task automatic test_store_half();
        drive_packet(2'b10, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_BEEF, 5'd2, 1'b1);
        @(negedge clk);
        valid_i = 1'b0;
        total++; if (dmem_req_o !== 1'b1) $display("FAIL sh_req: got %h want 1", dmem_req_o); else passed++;
        total++; if (dmem_we_o !== 1'b1) $display("FAIL sh_we: got %h want 1", dmem_we_o); else passed++;
        total++; if (dmem_be_o !== 4'b1100) $display("FAIL sh_be: got %b want 1100", dmem_be_o); else passed++;
        total++; if (dmem_wdata_o !== 32'hBEEF_BEEF) $display("FAIL sh_wdata: got %h want beefbeef", dmem_wdata_o); else passed++;
        total++; if (dmem_addr_o !== 32'h200) $display("FAIL sh_addr: got %h want 00000200", dmem_addr_o); else passed++;
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        total++; if (valid_o !== 1'b1) $display("FAIL sh_valid: got %h want 1", valid_o); else passed++;
        total++; if (wb_en_o !== 1'b0) $display("FAIL sh_wben: got %h want 0", wb_en_o); else passed++;
        total++; if (wb_data_o !== 32'h0) $display("FAIL sh_data: got %h want 0", wb_data_o); else passed++;
        total++; if (dmem_req_o !== 1'b0) $display("FAIL sh_req_end: got %h want 0", dmem_req_o); else passed++;
        // byte store lane replication
        drive_packet(2'b10, 2'b00, 1'b0, 32'h0000_0301, 32'h1234_56A5, 5'd2, 1'b0);
        @(negedge clk);
        valid_i = 1'b0;
        total++; if (dmem_be_o !== 4'b0010) $display("FAIL sb_be: got %b want 0010", dmem_be_o); else passed++;
        total++; if (dmem_wdata_o !== 32'hA5A5_A5A5) $display("FAIL sb_wdata: got %h want a5a5a5a5", dmem_wdata_o); else passed++;
        dmem_ack_i = 1'b1;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        total++; if (valid_o !== 1'b1) $display("FAIL sb_valid: got %h want 1", valid_o); else passed++;
    endtask

    task automatic test_misaligned();
        drive_packet(2'b01, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 5'd9, 1'b1);
        @(negedge clk);
        valid_i = 1'b0;
        total++; if (dmem_req_o !== 1'b0) $display("FAIL mis_req: got %h want 0", dmem_req_o); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL mis_stall: got %h want 0", stall_o); else passed++;
        total++; if (valid_o !== 1'b1) $display("FAIL mis_valid: got %h want 1", valid_o); else passed++;
        total++; if (wb_en_o !== 1'b0) $display("FAIL mis_wben: got %h want 0", wb_en_o); else passed++;
        total++; if (misalign_o !== 1'b1) $display("FAIL mis_flag: got %h want 1", misalign_o); else passed++;
        total++; if (wb_data_o !== 32'h0) $display("FAIL mis_data: got %h want 0", wb_data_o); else passed++;
        total++; if (dest_reg_addr_o !== 5'd9) $display("FAIL mis_dest: got %0d want 9", dest_reg_addr_o); else passed++;
        @(negedge clk);
        total++; if (misalign_o !== 1'b0) $display("FAIL mis_pulse: got %h want 0", misalign_o); else passed++;
        // odd half address is misaligned; even-but-not-word half is not
        drive_packet(2'b01, 2'b01, 1'b0, 32'h0000_0103, 32'h0, 5'd9, 1'b1);
        @(negedge clk);
        valid_i = 1'b0;
        total++; if (misalign_o !== 1'b1) $display("FAIL mish_flag: got %h want 1", misalign_o); else passed++;
    endtask

    task automatic test_back_to_back();
        drive_packet(2'b01, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 5'd3, 1'b1);
        @(negedge clk);
        drive_packet(2'b00, 2'b00, 1'b0, 32'h0000_0055, 32'h0, 5'd4, 1'b1);
        total++; if (stall_o !== 1'b1) $display("FAIL b2b_stall1: got %h want 1", stall_o); else passed++;
        @(negedge clk);
        total++; if (stall_o !== 1'b1) $display("FAIL b2b_stall2: got %h want 1", stall_o); else passed++;
        total++; if (valid_o !== 1'b0) $display("FAIL b2b_held: got %h want 0", valid_o); else passed++;
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        total++; if (valid_o !== 1'b1) $display("FAIL b2b_v1: got %h want 1", valid_o); else passed++;
        total++; if (wb_data_o !== 32'h1234_5678) $display("FAIL b2b_d1: got %h want 12345678", wb_data_o); else passed++;
        total++; if (dest_reg_addr_o !== 5'd3) $display("FAIL b2b_dest1: got %0d want 3", dest_reg_addr_o); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL b2b_stall3: got %h want 0", stall_o); else passed++;
        @(negedge clk);
        valid_i = 1'b0;
        total++; if (valid_o !== 1'b1) $display("FAIL b2b_v2: got %h want 1", valid_o); else passed++;
        total++; if (wb_data_o !== 32'h55) $display("FAIL b2b_d2: got %h want 00000055", wb_data_o); else passed++;
        total++; if (dest_reg_addr_o !== 5'd4) $display("FAIL b2b_dest2: got %0d want 4", dest_reg_addr_o); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        drive_packet(2'b01, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 5'd11, 1'b1);
        @(negedge clk);
        valid_i = 1'b0;
        total++; if (dmem_req_o !== 1'b1) $display("FAIL rmw_req: got %h want 1", dmem_req_o); else passed++;
        #1 rst = 1'b1;
        #1;
        total++; if (dmem_req_o !== 1'b0) $display("FAIL rmw_async: got %h want 0", dmem_req_o); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL rmw_stall: got %h want 0", stall_o); else passed++;
        @(negedge clk);
        rst = 1'b0;
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        total++; if (valid_o !== 1'b0) $display("FAIL rmw_lateack: got %h want 0", valid_o); else passed++;
        total++; if (dmem_req_o !== 1'b0) $display("FAIL rmw_req2: got %h want 0", dmem_req_o); else passed++;
        drive_packet(2'b00, 2'b00, 1'b0, 32'h0000_0077, 32'h0, 5'd6, 1'b1);
        @(negedge clk);
        valid_i = 1'b0;
        total++; if (valid_o !== 1'b1) $display("FAIL rmw_next_valid: got %h want 1", valid_o); else passed++;
        total++; if (wb_data_o !== 32'h77) $display("FAIL rmw_next_data: got %h want 00000077", wb_data_o); else passed++;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_byte(1'b0, 32'hFFFF_FF80);
        test_load_byte(1'b1, 32'h0000_0080);
        test_store_half();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
